// File: rtl/ask4_pkg.sv
// rtl/ask4_pkg.sv - 4-ASK symbol codes and level mapping shared by TX mapper and RX slicer
package ask4_pkg;

    localparam logic [1:0] SYM_P3 = 2'b01;
    localparam logic [1:0] SYM_P1 = 2'b00;
    localparam logic [1:0] SYM_M1 = 2'b11;
    localparam logic [1:0] SYM_M3 = 2'b10;

    localparam int SAMPLE_W = 18;

    // Outer level is built from shift-and-add so a constant level_a folds away entirely.
    function automatic logic signed [SAMPLE_W-1:0] ask4_level(
        input logic [1:0]                 sym,
        input logic signed [SAMPLE_W-1:0] level_a
    );
        logic signed [SAMPLE_W-1:0] outer;
        outer = (level_a <<< 1) + level_a;
        case (sym)
            SYM_P3:  ask4_level = outer;
            SYM_P1:  ask4_level = level_a;
            SYM_M1:  ask4_level = -level_a;
            default: ask4_level = -outer;
        endcase
    endfunction

endpackage

// File: rtl/sym_fifo.sv
// rtl/sym_fifo.sv - generic synchronous FIFO, asynchronous active-high reset
module sym_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/mapper_4_ask_tx.sv
// rtl/mapper_4_ask_tx.sv - 4-ASK TX mapper: symbol FIFO, sample counter, level register, underflow flag
module mapper_4_ask_tx
    import ask4_pkg::*;
#(
    parameter int                         SPS        = 4,
    parameter logic signed [SAMPLE_W-1:0] LEVEL_A    = 18'sd21845,
    parameter int                         FIFO_DEPTH = 4,
    parameter bit                         ZERO_STUFF = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic [1:0]                 sym_in,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    output logic signed [SAMPLE_W-1:0] out_sig,
    output logic                       sym_strobe,
    output logic                       underflow,
    input  logic                       clr_underflow
);

    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;

    logic [CW-1:0]              cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] out_q, out_d;
    logic                       strobe_q, strobe_d;
    logic                       underflow_q, underflow_d;

    logic       fifo_full, fifo_empty, boundary, pop;
    logic [1:0] head;

    sym_fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (sym_valid && !fifo_full),
        .din_i   (sym_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign boundary = clk_en && (cnt_q == '0);
    assign pop      = boundary && !fifo_empty;

    always_comb begin
        cnt_d       = cnt_q;
        out_d       = out_q;
        strobe_d    = 1'b0;
        underflow_d = underflow_q;
        if (clr_underflow) underflow_d = 1'b0;
        if (clk_en) begin
            cnt_d = (cnt_q == CW'(SPS - 1)) ? '0 : cnt_q + CW'(1);
            if (boundary) begin
                // An empty boundary still consumes its slot so symbol timing stays on grid.
                if (fifo_empty) begin
                    out_d       = '0;
                    underflow_d = 1'b1;
                end else begin
                    out_d    = ask4_level(head, LEVEL_A);
                    strobe_d = 1'b1;
                end
            end else if (ZERO_STUFF) begin
                out_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            out_q       <= '0;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            strobe_q    <= strobe_d;
            underflow_q <= underflow_d;
        end
    end

    assign sym_ready  = !fifo_full;
    assign out_sig    = out_q;
    assign sym_strobe = strobe_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_mapper_4_ask_tx.sv
// tb/tb_mapper_4_ask_tx.sv - self-checking bench for mapper_4_ask_tx (zero-stuff and hold variants)
module tb_mapper_4_ask_tx;

    localparam int SPS   = 4;
    localparam int DEPTH = 4;
    localparam int A     = 21845;

    logic              clk = 1'b0, reset = 1'b1, clk_en = 1'b0, sym_valid = 1'b0, clr_underflow = 1'b0;
    logic [1:0]        sym_in = 2'b00;
    logic              rdy_zs, rdy_hd, stb_zs, stb_hd, uf_zs, uf_hd;
    logic signed [17:0] out_zs, out_hd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] mq[$];
    logic [1:0] sent[$];
    int         mk, m_out_zs, m_out_hd;
    bit         m_stb, m_uf;

    int         exp_zs [16] = '{65535, 0, 0, 0, 21845, 0, 0, 0, -21845, 0, 0, 0, -65535, 0, 0, 0};
    int         exp_hd [16] = '{65535, 65535, 65535, 65535, 21845, 21845, 21845, 21845,
                                -21845, -21845, -21845, -21845, -65535, -65535, -65535, -65535};
    logic [1:0] preload [4] = '{2'b01, 2'b00, 2'b11, 2'b10};

    always #5 clk = ~clk;

    mapper_4_ask_tx #(.SPS(SPS), .LEVEL_A(18'sd21845), .FIFO_DEPTH(DEPTH), .ZERO_STUFF(1'b1)) dut_zs (
        .clk(clk), .reset(reset), .clk_en(clk_en), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(rdy_zs), .out_sig(out_zs), .sym_strobe(stb_zs), .underflow(uf_zs),
        .clr_underflow(clr_underflow));

    mapper_4_ask_tx #(.SPS(SPS), .LEVEL_A(18'sd21845), .FIFO_DEPTH(DEPTH), .ZERO_STUFF(1'b0)) dut_hd (
        .clk(clk), .reset(reset), .clk_en(clk_en), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(rdy_hd), .out_sig(out_hd), .sym_strobe(stb_hd), .underflow(uf_hd),
        .clr_underflow(clr_underflow));

    function automatic int level(input logic [1:0] s);
        case (s)
            2'b01:   return 3 * A;
            2'b00:   return A;
            2'b11:   return -A;
            default: return -3 * A;
        endcase
    endfunction

    // Receiver-side decision with outer threshold at 2A.
    function automatic logic [1:0] slice(input int x);
        if (x >= 2 * A) return 2'b01;
        if (x >= 0)     return 2'b00;
        if (x >= -2 * A) return 2'b11;
        return 2'b10;
    endfunction

    task automatic clear_model();
        mq.delete();
        sent.delete();
        mk = 0; m_out_zs = 0; m_out_hd = 0; m_stb = 0; m_uf = 0;
    endtask

    // Drive one clock, advance the model from the sample index mk (symbol slot = mk mod SPS).
    task automatic tick(input bit en, input bit v, input logic [1:0] s, input bit clr);
        bit bnd, popped, accept;
        clk_en = en; sym_valid = v; sym_in = s; clr_underflow = clr;
        bnd    = en && (mk % SPS == 0);
        popped = bnd && (mq.size() > 0);
        accept = v && (mq.size() < DEPTH);
        m_stb  = popped;
        if (clr) m_uf = 0;
        if (bnd && !popped) m_uf = 1;
        if (bnd) begin
            m_out_zs = popped ? level(mq[0]) : 0;
            m_out_hd = m_out_zs;
        end else if (en) begin
            m_out_zs = 0;
        end
        if (popped) void'(mq.pop_front());
        if (accept) begin
            mq.push_back(s);
            sent.push_back(s);
        end
        if (en) mk++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; clk_en = 0; sym_valid = 0; clr_underflow = 0;
        clear_model();
        #2;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (out_zs !== 18'sd0 || out_hd !== 18'sd0) begin n_fail++; $display("FAIL reset_out zs=%0d hd=%0d expected 0", out_zs, out_hd); end
        n_checks++; if (stb_zs !== 1'b0 || uf_zs !== 1'b0) begin n_fail++; $display("FAIL reset_flags stb=%b uf=%b expected 0 0", stb_zs, uf_zs); end
        do_reset();
        n_checks++; if (rdy_zs !== 1'b1 || rdy_hd !== 1'b1) begin n_fail++; $display("FAIL reset_ready %b/%b expected 1", rdy_zs, rdy_hd); end
    endtask

    task automatic test_mapping();
        do_reset();
        for (int i = 0; i < 4; i++) tick(0, 1, preload[i], 0);
        for (int i = 0; i < 16; i++) begin
            tick(1, 0, 2'b00, 0);
            n_checks++; if (out_zs !== 18'(exp_zs[i])) begin n_fail++; $display("FAIL map_zs[%0d] got %0d expected %0d", i, out_zs, exp_zs[i]); end
            n_checks++; if (out_hd !== 18'(exp_hd[i])) begin n_fail++; $display("FAIL map_hold[%0d] got %0d expected %0d", i, out_hd, exp_hd[i]); end
            n_checks++; if (stb_zs !== (i % 4 == 0) || stb_hd !== (i % 4 == 0)) begin n_fail++; $display("FAIL map_strobe[%0d] got %b/%b expected %b", i, stb_zs, stb_hd, (i % 4 == 0)); end
            n_checks++; if (uf_zs !== 1'b0 || uf_hd !== 1'b0) begin n_fail++; $display("FAIL map_no_underflow[%0d] got %b/%b expected 0", i, uf_zs, uf_hd); end
        end
    endtask

    task automatic test_underflow();
        tick(1, 0, 2'b00, 0);
        n_checks++; if (uf_zs !== 1'b1 || uf_hd !== 1'b1) begin n_fail++; $display("FAIL uf_set got %b/%b expected 1", uf_zs, uf_hd); end
        n_checks++; if (out_zs !== 18'sd0 || out_hd !== 18'sd0 || stb_zs !== 1'b0) begin n_fail++; $display("FAIL uf_out got %0d/%0d stb=%b expected 0/0 stb=0", out_zs, out_hd, stb_zs); end
        tick(0, 0, 2'b00, 1);
        n_checks++; if (uf_zs !== 1'b0) begin n_fail++; $display("FAIL uf_clear got %b expected 0", uf_zs); end
        for (int i = 0; i < 3; i++) tick(1, 0, 2'b00, 0);
        tick(1, 0, 2'b00, 1);
        n_checks++; if (uf_zs !== 1'b1 || uf_hd !== 1'b1) begin n_fail++; $display("FAIL uf_set_beats_clr got %b/%b expected 1", uf_zs, uf_hd); end
        tick(0, 0, 2'b00, 1);
        n_checks++; if (uf_zs !== 1'b0 || uf_hd !== 1'b0) begin n_fail++; $display("FAIL uf_clear2 got %b/%b expected 0", uf_zs, uf_hd); end
    endtask

    task automatic test_full();
        logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
        int         n_stb;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rdy_zs !== 1'b1) begin n_fail++; $display("FAIL full_ready_before_push%0d got %b expected 1", i, rdy_zs); end
            tick(0, 1, 2'(i), 0);
        end
        n_checks++; if (rdy_zs !== 1'b0 || rdy_hd !== 1'b0) begin n_fail++; $display("FAIL full_ready_low got %b/%b expected 0", rdy_zs, rdy_hd); end
        tick(0, 1, 2'b11, 0);
        tick(1, 1, 2'b11, 0);
        n_checks++; if (stb_zs !== 1'b1 || out_zs !== 18'sd21845) begin n_fail++; $display("FAIL full_first_pop stb=%b out=%0d expected 1 21845", stb_zs, out_zs); end
        n_checks++; if (rdy_zs !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop got %b expected 1", rdy_zs); end
        tick(0, 1, 2'b11, 0);
        n_stb = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1, 0, 2'b00, 0);
            if (stb_zs === 1'b1) begin
                if (n_stb < 4) begin
                    n_checks++; if (slice(int'(out_zs)) !== exp_order[n_stb]) begin n_fail++; $display("FAIL full_order[%0d] got %b expected %b", n_stb, slice(int'(out_zs)), exp_order[n_stb]); end
                end
                n_stb++;
            end
        end
        n_checks++; if (n_stb != 4) begin n_fail++; $display("FAIL full_strobe_count got %0d expected 4", n_stb); end
    endtask

    task automatic test_sparse_enable();
        int j;
        do_reset();
        for (int i = 0; i < 4; i++) tick(0, 1, preload[i], 0);
        j = 0;
        for (int c = 0; c < 48; c++) begin
            tick(c % 3 == 2, 0, 2'b00, 0);
            if (c % 3 == 2) begin
                n_checks++; if (out_zs !== 18'(exp_zs[j]) || out_hd !== 18'(exp_hd[j])) begin n_fail++; $display("FAIL sparse_out[%0d] got %0d/%0d expected %0d/%0d", j, out_zs, out_hd, exp_zs[j], exp_hd[j]); end
                n_checks++; if (stb_zs !== (j % 4 == 0)) begin n_fail++; $display("FAIL sparse_strobe[%0d] got %b expected %b", j, stb_zs, (j % 4 == 0)); end
                j++;
            end else begin
                n_checks++; if (stb_zs !== 1'b0) begin n_fail++; $display("FAIL sparse_idle_strobe c=%0d got %b expected 0", c, stb_zs); end
                n_checks++; if (out_zs !== 18'((j == 0) ? 0 : exp_zs[j-1])) begin n_fail++; $display("FAIL sparse_hold c=%0d got %0d expected %0d", c, out_zs, (j == 0) ? 0 : exp_zs[j-1]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n_stb;
        do_reset();
        for (int i = 0; i < 3; i++) tick(0, 1, preload[i], 0);
        tick(1, 0, 2'b00, 0);
        tick(1, 0, 2'b00, 0);
        #2;
        reset = 1'b1;
        clear_model();
        #1;
        n_checks++; if (out_zs !== 18'sd0 || out_hd !== 18'sd0) begin n_fail++; $display("FAIL mid_reset_out got %0d/%0d expected 0", out_zs, out_hd); end
        n_checks++; if (stb_zs !== 1'b0 || uf_zs !== 1'b0 || rdy_zs !== 1'b1) begin n_fail++; $display("FAIL mid_reset_flags stb=%b uf=%b rdy=%b expected 0 0 1", stb_zs, uf_zs, rdy_zs); end
        @(negedge clk);
        reset = 1'b0;
        n_stb = 0;
        for (int i = 0; i < 2 * SPS; i++) begin
            tick(1, 0, 2'b00, 0);
            if (i == 0) begin
                n_checks++; if (uf_zs !== 1'b1) begin n_fail++; $display("FAIL mid_first_boundary_uf got %b expected 1", uf_zs); end
            end
            if (stb_zs === 1'b1 || out_zs !== 18'sd0) n_stb++;
        end
        n_checks++; if (n_stb != 0) begin n_fail++; $display("FAIL mid_stale_symbols got %0d samples expected 0", n_stb); end
    endtask

    task automatic test_random();
        logic [1:0] s;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            n_checks++; if (rdy_zs !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b expected %b", c, rdy_zs, (mq.size() < DEPTH)); end
            s = 2'($urandom);
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, s, $urandom_range(0, 15) == 0);
            n_checks++; if (out_zs !== 18'(m_out_zs) || out_hd !== 18'(m_out_hd)) begin n_fail++; $display("FAIL rnd_out c=%0d got %0d/%0d expected %0d/%0d", c, out_zs, out_hd, m_out_zs, m_out_hd); end
            n_checks++; if (stb_zs !== m_stb || uf_zs !== m_uf || uf_hd !== m_uf) begin n_fail++; $display("FAIL rnd_flags c=%0d stb=%b uf=%b/%b expected %b %b", c, stb_zs, uf_zs, uf_hd, m_stb, m_uf); end
            if (m_stb) begin
                n_checks++;
                if (sent.size() == 0) begin
                    n_fail++; $display("FAIL rnd_roundtrip c=%0d strobe with no symbol sent expected none", c);
                end else if (slice(int'(out_zs)) !== sent[0] || slice(int'(out_hd)) !== sent[0]) begin
                    n_fail++; $display("FAIL rnd_roundtrip c=%0d got %b/%b expected %b", c, slice(int'(out_zs)), slice(int'(out_hd)), sent[0]);
                end
                if (sent.size() > 0) void'(sent.pop_front());
            end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_mapping();
        test_underflow();
        test_full();
        test_sparse_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
